// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] IC_F3 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IC = 2'd1,
        ST_GNT_DM = 2'd2
    } arb_state_e;

    // Round-robin pick from IDLE: with both pending, the port not served last wins.
    function automatic logic pick_dm(input logic ic_req, input logic dm_req, input logic last_dm);
        return dm_req && (!ic_req || !last_dm);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester (I-cache, data) and memory-side signals around the arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic            i_ic_req;
    logic [XLEN-1:0] i_ic_addr;
    logic            o_ic_ready;
    logic [XLEN-1:0] o_ic_rdata;
    logic            o_ic_err;

    logic            i_dm_req;
    logic            i_dm_wen;
    logic [XLEN-1:0] i_dm_addr;
    logic [XLEN-1:0] i_dm_wd;
    logic [2:0]      i_dm_f3;
    logic            o_dm_ready;
    logic [XLEN-1:0] o_dm_rdata;
    logic            o_dm_err;

    logic            o_mem_req;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wd;
    logic [2:0]      o_mem_f3;
    logic            o_mem_wen;
    logic            i_mem_ready;
    logic [XLEN-1:0] i_mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_ic_req, i_ic_addr,
        output o_ic_ready, o_ic_rdata, o_ic_err,
        input  i_dm_req, i_dm_wen, i_dm_addr, i_dm_wd, i_dm_f3,
        output o_dm_ready, o_dm_rdata, o_dm_err,
        output o_mem_req, o_mem_addr, o_mem_wd, o_mem_f3, o_mem_wen,
        input  i_mem_ready, i_mem_rdata
    );

    // Environment side (core ports and memory model).
    modport master (
        output i_ic_req, i_ic_addr,
        input  o_ic_ready, o_ic_rdata, o_ic_err,
        output i_dm_req, i_dm_wen, i_dm_addr, i_dm_wd, i_dm_f3,
        input  o_dm_ready, o_dm_rdata, o_dm_err,
        input  o_mem_req, o_mem_addr, o_mem_wd, o_mem_f3, o_mem_wen,
        output i_mem_ready, i_mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Timeout counter: flags a granted transaction that has waited TIMEOUT cycles.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_ready,
    output logic o_expire
);

    localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: restart on a new grant, advance on each unanswered grant cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && !i_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_enable && !i_ready && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between I-cache refill and data ports.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);

    arb_state_e      state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic [2:0]      f3_q, f3_d;
    logic            wen_q, wen_d;

    logic busy;
    logic expire;
    logic done;
    logic grant_ic;
    logic grant_dm;

    assign busy = (state_q != ST_IDLE);
    assign done = busy && (bus.i_mem_ready || expire);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (grant_ic || grant_dm),
        .i_enable (busy),
        .i_ready  (bus.i_mem_ready),
        .o_expire (expire)
    );

    // Next-state: arbitration from IDLE, back-to-back handover on completion, field latching.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        f3_d       = f3_q;
        wen_d      = wen_q;
        grant_ic   = 1'b0;
        grant_dm   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_ic_req || bus.i_dm_req) begin
                    if (pick_dm(bus.i_ic_req, bus.i_dm_req, last_gnt_q)) begin
                        grant_dm = 1'b1;
                    end else begin
                        grant_ic = 1'b1;
                    end
                end
            end
            ST_GNT_IC: begin
                if (done) begin
                    if (bus.i_dm_req) begin
                        grant_dm = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GNT_DM: begin
                if (done) begin
                    if (bus.i_ic_req) begin
                        grant_ic = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_ic) begin
            state_d    = ST_GNT_IC;
            last_gnt_d = 1'b0;
            addr_d     = bus.i_ic_addr;
            wd_d       = '0;
            f3_d       = IC_F3;
            wen_d      = 1'b0;
        end else if (grant_dm) begin
            state_d    = ST_GNT_DM;
            last_gnt_d = 1'b1;
            addr_d     = bus.i_dm_addr;
            wd_d       = bus.i_dm_wd;
            f3_d       = bus.i_dm_f3;
            wen_d      = bus.i_dm_wen;
        end
    end

    // State and latched-transaction registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            f3_q       <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            f3_q       <= f3_d;
            wen_q      <= wen_d;
        end
    end

    // Outputs: memory side from latched fields, completion routed only to the granted port.
    always_comb begin
        bus.o_mem_req  = busy;
        bus.o_mem_addr = addr_q;
        bus.o_mem_wd   = wd_q;
        bus.o_mem_f3   = f3_q;
        bus.o_mem_wen  = busy && wen_q;

        bus.o_ic_ready = 1'b0;
        bus.o_ic_rdata = '0;
        bus.o_ic_err   = 1'b0;
        bus.o_dm_ready = 1'b0;
        bus.o_dm_rdata = '0;
        bus.o_dm_err   = 1'b0;

        if (state_q == ST_GNT_IC) begin
            bus.o_ic_ready = done;
            bus.o_ic_err   = expire;
            bus.o_ic_rdata = bus.i_mem_ready ? bus.i_mem_rdata : '0;
        end else if (state_q == ST_GNT_DM) begin
            bus.o_dm_ready = done;
            bus.o_dm_err   = expire;
            bus.o_dm_rdata = bus.i_mem_ready ? bus.i_mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT = 4).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst             = 1'b1;
        bus.i_ic_req    = 1'b0;
        bus.i_ic_addr   = '0;
        bus.i_dm_req    = 1'b0;
        bus.i_dm_wen    = 1'b0;
        bus.i_dm_addr   = '0;
        bus.i_dm_wd     = '0;
        bus.i_dm_f3     = '0;
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = '0;

        // Reset state.
        next_cycle(); settle();
        check("rst mem_req",  32'(bus.o_mem_req),  0);
        check("rst mem_addr", bus.o_mem_addr,      0);
        check("rst mem_wd",   bus.o_mem_wd,        0);
        check("rst mem_f3",   32'(bus.o_mem_f3),   0);
        check("rst mem_wen",  32'(bus.o_mem_wen),  0);
        check("rst ic_ready", 32'(bus.o_ic_ready), 0);
        check("rst dm_ready", 32'(bus.o_dm_ready), 0);
        rst = 1'b0;

        // IC-only read, memory answers in grant cycle 4.
        next_cycle();
        bus.i_ic_req  = 1'b1;
        bus.i_ic_addr = 32'h100;
        settle();
        check("ic c0 mem_req", 32'(bus.o_mem_req), 0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); settle();
            check("ic wait mem_req",  32'(bus.o_mem_req),  1);
            check("ic wait ic_ready", 32'(bus.o_ic_ready), 0);
            if (c == 1) begin
                check("ic mem_addr", bus.o_mem_addr,     32'h100);
                check("ic mem_f3",   32'(bus.o_mem_f3),  32'h2);
                check("ic mem_wen",  32'(bus.o_mem_wen), 0);
            end
        end
        next_cycle();
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'hDEADBEEF;
        settle();
        check("ic c4 mem_req",  32'(bus.o_mem_req),  1);
        check("ic c4 ic_ready", 32'(bus.o_ic_ready), 1);
        check("ic c4 ic_rdata", bus.o_ic_rdata,      32'hDEADBEEF);
        check("ic c4 ic_err",   32'(bus.o_ic_err),   0);
        check("ic c4 mem_wen",  32'(bus.o_mem_wen),  0);
        check("ic c4 dm_ready", 32'(bus.o_dm_ready), 0);
        check("ic c4 dm_rdata", bus.o_dm_rdata,      0);
        next_cycle();
        bus.i_ic_req    = 1'b0;
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = '0;
        settle();
        check("ic c5 mem_req",  32'(bus.o_mem_req),  0);
        check("ic c5 ic_ready", 32'(bus.o_ic_ready), 0);

        // Simultaneous requests after reset: DM first, then IC back-to-back.
        rst = 1'b1; settle(); rst = 1'b0;
        next_cycle();
        bus.i_ic_req    = 1'b1;
        bus.i_ic_addr   = 32'h1000;
        bus.i_dm_req    = 1'b1;
        bus.i_dm_wen    = 1'b0;
        bus.i_dm_addr   = 32'h2000;
        bus.i_dm_f3     = 3'b100;
        settle();
        next_cycle(); settle();
        check("sim dm mem_addr", bus.o_mem_addr,     32'h2000);
        check("sim dm mem_f3",   32'(bus.o_mem_f3),  32'h4);
        check("sim dm mem_wen",  32'(bus.o_mem_wen), 0);
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'hA5A50001;
        settle();
        check("sim dm_ready", 32'(bus.o_dm_ready), 1);
        check("sim dm_rdata", bus.o_dm_rdata,      32'hA5A50001);
        check("sim ic_ready", 32'(bus.o_ic_ready), 0);
        check("sim ic_rdata", bus.o_ic_rdata,      0);
        bus.i_dm_req = 1'b0;
        next_cycle();
        bus.i_mem_ready = 1'b0;
        settle();
        check("sim ic mem_req",  32'(bus.o_mem_req), 1);
        check("sim ic mem_addr", bus.o_mem_addr,     32'h1000);
        check("sim ic mem_f3",   32'(bus.o_mem_f3),  32'h2);
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'h00001111;
        settle();
        check("sim ic2 ic_ready", 32'(bus.o_ic_ready), 1);
        check("sim ic2 ic_rdata", bus.o_ic_rdata,      32'h00001111);
        check("sim ic2 dm_ready", 32'(bus.o_dm_ready), 0);
        bus.i_ic_req = 1'b0;
        next_cycle();
        bus.i_mem_ready = 1'b0;
        settle();
        check("sim end mem_req", 32'(bus.o_mem_req), 0);

        // Round-robin: IC was served last, so DM leads; six alternating grants.
        bus.i_ic_req    = 1'b1;
        bus.i_ic_addr   = 32'h1000;
        bus.i_dm_req    = 1'b1;
        bus.i_dm_addr   = 32'h2000;
        bus.i_dm_f3     = 3'b010;
        bus.i_mem_ready = 1'b1;
        bus.i_mem_rdata = 32'h0000CAFE;
        for (int k = 0; k < 6; k++) begin
            next_cycle(); settle();
            if (k % 2 == 0) begin
                check("rr dm mem_addr", bus.o_mem_addr,      32'h2000);
                check("rr dm_ready",    32'(bus.o_dm_ready), 1);
            end else begin
                check("rr ic mem_addr", bus.o_mem_addr,      32'h1000);
                check("rr ic_ready",    32'(bus.o_ic_ready), 1);
            end
            if (k == 5) begin
                bus.i_ic_req = 1'b0;
                bus.i_dm_req = 1'b0;
            end
        end
        next_cycle();
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = '0;
        settle();
        check("rr end mem_req", 32'(bus.o_mem_req), 0);

        // DM store; requester inputs change mid-grant without effect.
        bus.i_dm_req  = 1'b1;
        bus.i_dm_wen  = 1'b1;
        bus.i_dm_addr = 32'h2004;
        bus.i_dm_wd   = 32'h55;
        bus.i_dm_f3   = 3'b000;
        next_cycle(); settle();
        check("st mem_wen",  32'(bus.o_mem_wen), 1);
        check("st mem_f3",   32'(bus.o_mem_f3),  0);
        check("st mem_wd",   bus.o_mem_wd,       32'h55);
        check("st mem_addr", bus.o_mem_addr,     32'h2004);
        bus.i_dm_addr = 32'hFFFF0000;
        bus.i_dm_wd   = 32'h99;
        next_cycle(); settle();
        check("st held mem_addr", bus.o_mem_addr, 32'h2004);
        check("st held mem_wd",   bus.o_mem_wd,   32'h55);
        bus.i_mem_ready = 1'b1;
        settle();
        check("st dm_ready", 32'(bus.o_dm_ready), 1);
        check("st dm_err",   32'(bus.o_dm_err),   0);
        bus.i_dm_req = 1'b0;
        bus.i_dm_wen = 1'b0;
        next_cycle();
        bus.i_mem_ready = 1'b0;
        settle();
        check("st end mem_req", 32'(bus.o_mem_req), 0);
        check("st end mem_wen", 32'(bus.o_mem_wen), 0);

        // Timeout: memory never answers a DM load.
        bus.i_dm_req    = 1'b1;
        bus.i_dm_addr   = 32'h300;
        bus.i_dm_f3     = 3'b010;
        bus.i_mem_rdata = 32'h1234;
        for (int g = 1; g <= 3; g++) begin
            next_cycle(); settle();
            check("to wait mem_req",  32'(bus.o_mem_req),  1);
            check("to wait dm_ready", 32'(bus.o_dm_ready), 0);
        end
        next_cycle(); settle();
        check("to g4 dm_ready", 32'(bus.o_dm_ready), 1);
        check("to g4 dm_err",   32'(bus.o_dm_err),   1);
        check("to g4 dm_rdata", bus.o_dm_rdata,      0);
        bus.i_dm_req = 1'b0;
        next_cycle(); settle();
        check("to idle mem_req", 32'(bus.o_mem_req), 0);
        bus.i_mem_ready = 1'b1;
        settle();
        check("to stray dm_ready", 32'(bus.o_dm_ready), 0);
        check("to stray ic_ready", 32'(bus.o_ic_ready), 0);
        next_cycle();
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = '0;

        // Async reset mid-grant, then DM wins after release.
        bus.i_ic_req  = 1'b1;
        bus.i_ic_addr = 32'h400;
        next_cycle(); settle();
        check("ar grant mem_req", 32'(bus.o_mem_req), 1);
        #2;
        rst             = 1'b1;
        bus.i_mem_ready = 1'b1;
        settle();
        check("ar mem_req",  32'(bus.o_mem_req),  0);
        check("ar ic_ready", 32'(bus.o_ic_ready), 0);
        check("ar mem_wen",  32'(bus.o_mem_wen),  0);
        check("ar mem_addr", bus.o_mem_addr,      0);
        bus.i_mem_ready = 1'b0;
        bus.i_dm_req    = 1'b1;
        bus.i_dm_addr   = 32'h500;
        next_cycle();
        rst = 1'b0;
        settle();
        check("ar idle mem_req", 32'(bus.o_mem_req), 0);
        next_cycle(); settle();
        check("ar dm mem_req",  32'(bus.o_mem_req), 1);
        check("ar dm mem_addr", bus.o_mem_addr,     32'h500);
        bus.i_mem_ready = 1'b1;
        bus.i_ic_req    = 1'b0;
        bus.i_dm_req    = 1'b0;
        settle();
        check("ar dm_ready", 32'(bus.o_dm_ready), 1);
        next_cycle();
        bus.i_mem_ready = 1'b0;
        settle();
        check("ar end mem_req", 32'(bus.o_mem_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
